// File: rtl/bit_deserializer_pkg.sv
// bit_deserializer_pkg
//   Shared types and helpers for the serial-to-parallel collector.
//   out_state_t : output holding register state (empty / holding a word)
//   cnt_w()     : width of a counter that must represent 0..width
package bit_deserializer_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_shift_reg.sv
// bit_shift_reg
//   WIDTH-bit serial-in shift register.
//   clk      : rising-edge clock
//   rst_n    : async active-low reset, clears value
//   clr      : sync clear, wins over shift_en
//   shift_en : shift bit_in in on this edge
//   bit_in   : serial data
//   value    : register contents
//   MSB_FIRST=1 shifts toward the MSB (new bit enters at [0]), so the first
//   bit ends up in [WIDTH-1] after WIDTH shifts. MSB_FIRST=0 mirrors that.
module bit_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_nxt;

  generate
    if (MSB_FIRST) begin : g_msb
      assign value_nxt = {value[WIDTH-2:0], bit_in};
    end else begin : g_lsb
      assign value_nxt = {bit_in, value[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        value <= '0;
    else if (clr)      value <= '0;
    else if (shift_en) value <= value_nxt;
  end

endmodule

// File: rtl/bit_deserializer.sv
// bit_deserializer
//   Collects WIDTH accepted serial bits into a word and presents it on a
//   valid/ready port. The bit stream cannot stall, so a word completing while
//   the previous one is still unconsumed is dropped and flags sticky overrun.
//   clk        : rising-edge clock
//   rst_n      : async active-low reset
//   bit_valid  : bit_in is accepted on this edge
//   bit_in     : serial data
//   sync_clr   : sync clear of all state, highest priority
//   word_out   : assembled word, held while word_valid
//   word_valid : word_out holds an unconsumed word
//   word_ready : consumer takes word_out when word_valid & word_ready
//   bit_count  : bits collected toward the next word (0..WIDTH-1)
//   overrun    : sticky, a completed word was dropped
//   All outputs are registered.
module bit_deserializer
  import bit_deserializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bit_valid,
  input  logic                    bit_in,
  input  logic                    sync_clr,
  output logic [WIDTH-1:0]        word_out,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [cnt_w(WIDTH)-1:0] bit_count,
  output logic                    overrun
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] word_q;
  logic             ovr_q;
  out_state_t       state_q, state_d;

  logic accept, complete, handshake;
  logic load_word, set_ovr;

  // sync_clr discards the bit offered on the same edge
  assign accept    = bit_valid & ~sync_clr;
  assign complete  = accept & (cnt_q == LAST);
  assign handshake = (state_q == OUT_FULL) & word_ready;

  // ---------------------------------------------------------------------------
  // Accumulator
  // ---------------------------------------------------------------------------
  bit_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (sync_clr),
    .shift_en (bit_valid),
    .bit_in   (bit_in),
    .value    (acc)
  );

  // The word loads on the edge that captures its last bit, so the output
  // register needs the post-shift value rather than acc itself.
  generate
    if (MSB_FIRST) begin : g_nxt_msb
      assign acc_nxt = {acc[WIDTH-2:0], bit_in};
    end else begin : g_nxt_lsb
      assign acc_nxt = {bit_in, acc[WIDTH-1:1]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_q <= '0;
    else if (sync_clr) cnt_q <= '0;
    else if (accept)   cnt_q <= complete ? '0 : cnt_q + CW'(1);
  end

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state_q <= OUT_EMPTY;
    else if (sync_clr) state_q <= OUT_EMPTY;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (complete)               state_d = OUT_FULL;
      OUT_FULL:  if (handshake && !complete) state_d = OUT_EMPTY;
      default:                               state_d = OUT_EMPTY;
    endcase
  end

  // A completion is only lost when the held word is not leaving on the
  // same edge; a simultaneous handshake frees the slot for the new word.
  always_comb begin
    load_word = 1'b0;
    set_ovr   = 1'b0;
    case (state_q)
      OUT_EMPTY: load_word = complete;
      OUT_FULL: begin
        load_word = complete & handshake;
        set_ovr   = complete & ~handshake;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output word and sticky overrun
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         word_q <= '0;
    else if (sync_clr)  word_q <= '0;
    else if (load_word) word_q <= acc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ovr_q <= 1'b0;
    else if (sync_clr) ovr_q <= 1'b0;
    else if (set_ovr)  ovr_q <= 1'b1;
  end

  assign word_out   = word_q;
  assign word_valid = (state_q == OUT_FULL);
  assign bit_count  = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Scoreboard bench: two instances (MSB-first and LSB-first) share all inputs.
// Each accepted word (handshake seen at negedge) is popped from a per-instance
// expected queue; cycle-exact checks are made #1 after clock edges.
module tb_bit_deserializer;

  logic       clk = 1'b0;
  logic       rst_n, bit_valid, bit_in, sync_clr, word_ready;
  logic [7:0] wo_a, wo_b;
  logic       wv_a, wv_b, ov_a, ov_b;
  logic [3:0] bc_a, bc_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .sync_clr(sync_clr), .word_out(wo_a), .word_valid(wv_a),
    .word_ready(word_ready), .bit_count(bc_a), .overrun(ov_a)
  );

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .sync_clr(sync_clr), .word_out(wo_b), .word_valid(wv_b),
    .word_ready(word_ready), .bit_count(bc_b), .overrun(ov_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // expected word for the MSB-first instance; LSB-first sees it bit-reversed
  task automatic expect_word(input logic [7:0] w);
    q_a.push_back(w);
    q_b.push_back(rev8(w));
  endtask

  // present one bit/enable for one edge, return #1 after that edge
  task automatic send(input logic b, input logic v);
    bit_in    = b;
    bit_valid = v;
    @(posedge clk);
    #1;
  endtask

  // n bits of w, MSB first
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) send(w[i], 1'b1);
  endtask

  // monitor: a word is consumed on the next edge when valid & ready
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wv_a === 1'b1 && word_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL word_a: unexpected word 0x%0h at %0t", wo_a, $time);
      end else chk("word_a", {24'd0, wo_a}, {24'd0, q_a.pop_front()});
    end
    if (rst_n === 1'b1 && wv_b === 1'b1 && word_ready === 1'b1) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL word_b: unexpected word 0x%0h at %0t", wo_b, $time);
      end else chk("word_b", {24'd0, wo_b}, {24'd0, q_b.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sync_clr = 1'b0; word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word_out", {24'd0, wo_a}, 32'd0);
    chk("rst_valid", {31'd0, wv_a}, 32'd0);
    chk("rst_count", {28'd0, bc_a}, 32'd0);
    chk("rst_overrun", {31'd0, ov_a}, 32'd0);
    rst_n = 1'b1;
    send(1'b0, 1'b0);

    // reset mid-word after 3 bits
    word_ready = 1'b1;
    send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
    chk("pre_rst_count", {28'd0, bc_a}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", {28'd0, bc_a}, 32'd0);
    chk("mid_rst_valid", {31'd0, wv_a}, 32'd0);
    rst_n = 1'b1;

    // 1,0,1,1,0,0,1,0 -> 0xB2 (LSB-first 0x4D), valid exactly on edge 8
    pat = 8'hB2;
    expect_word(pat);
    for (int i = 7; i >= 1; i--) begin
      send(pat[i], 1'b1);
      chk("early_valid", {31'd0, wv_a}, 32'd0);
    end
    send(pat[0], 1'b1);
    chk("edge8_valid", {31'd0, wv_a}, 32'd1);
    chk("edge8_word_a", {24'd0, wo_a}, 32'hB2);
    chk("edge8_word_b", {24'd0, wo_b}, 32'h4D);
    chk("edge8_count", {28'd0, bc_a}, 32'd0);
    send(1'b0, 1'b0);
    chk("consumed_valid", {31'd0, wv_a}, 32'd0);
    send(1'b0, 1'b0);
    chk("ready_no_valid", {31'd0, wv_a}, 32'd0);

    // enable gaps with toggling bit_in: 0,1,0,1,0,1,0,1 -> 0x55
    pat = 8'h55;
    expect_word(pat);
    for (int i = 7; i >= 0; i--) begin
      send(pat[i], 1'b1);
      for (int g = 0; g < 4; g++) send(g[0], 1'b0);
      if (i != 0) chk("gap_count", {28'd0, bc_a}, 32'(8 - i));
    end
    send(1'b0, 1'b0);

    // overrun: 0xA5 held, 0x3C dropped
    word_ready = 1'b0;
    expect_word(8'hA5);
    send_bits(8'hA5, 8);
    chk("ovr_first_valid", {31'd0, wv_a}, 32'd1);
    chk("ovr_first_flag", {31'd0, ov_a}, 32'd0);
    send_bits(8'h3C, 8);
    chk("ovr_word_held", {24'd0, wo_a}, 32'hA5);
    chk("ovr_flag_a", {31'd0, ov_a}, 32'd1);
    chk("ovr_flag_b", {31'd0, ov_b}, 32'd1);
    word_ready = 1'b1;
    send(1'b0, 1'b0);
    chk("ovr_drain_valid", {31'd0, wv_a}, 32'd0);
    chk("ovr_sticky", {31'd0, ov_a}, 32'd1);
    send(1'b0, 1'b0);
    chk("ovr_sticky2", {31'd0, ov_a}, 32'd1);
    sync_clr = 1'b1;
    send(1'b0, 1'b0);
    sync_clr = 1'b0;
    chk("ovr_cleared", {31'd0, ov_a}, 32'd0);

    // handshake on the edge completing the next word
    word_ready = 1'b0;
    expect_word(8'h96);
    send_bits(8'h96, 8);
    send_bits(8'h0F, 7);
    expect_word(8'h0F);
    word_ready = 1'b1;
    send(1'b1, 1'b1);
    chk("hs_cmpl_valid", {31'd0, wv_a}, 32'd1);
    chk("hs_cmpl_word_a", {24'd0, wo_a}, 32'h0F);
    chk("hs_cmpl_word_b", {24'd0, wo_b}, 32'hF0);
    chk("hs_cmpl_overrun", {31'd0, ov_a}, 32'd0);
    send(1'b0, 1'b0);
    chk("hs_cmpl_drain", {31'd0, wv_a}, 32'd0);

    // sync_clr together with a completing bit
    send_bits(8'hFF, 7);
    chk("clr_pre_count", {28'd0, bc_a}, 32'd7);
    sync_clr = 1'b1;
    send(1'b1, 1'b1);
    sync_clr = 1'b0;
    chk("clr_valid", {31'd0, wv_a}, 32'd0);
    chk("clr_count", {28'd0, bc_b}, 32'd0);
    send(1'b0, 1'b0);
    chk("clr_valid_later", {31'd0, wv_a}, 32'd0);

    // collection restarts cleanly after clear
    expect_word(8'hC3);
    send_bits(8'hC3, 8);
    chk("restart_word", {24'd0, wo_a}, 32'hC3);
    send(1'b0, 1'b0);

    for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) send(1'b0, 1'b0);
    chk("drain_a", q_a.size(), 32'd0);
    chk("drain_b", q_b.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bit_deserializer.md
# bit_deserializer

Serial-to-parallel collector that sits directly downstream of the enabled single-bit register stage. It consumes the registered bit stream together with its qualifying enable and assembles WIDTH consecutive accepted bits into a word. The word is presented on a valid/ready output port. Words that complete while the output is still held are dropped and flagged, because the bit stream cannot be stalled.

## Interface
- WIDTH, 8: bits per output word; legal range 2..32.
- MSB_FIRST, 1: 1 means the first accepted bit lands in word_out[WIDTH-1]; 0 means it lands in word_out[0].
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- bit_valid  input  1  qualifies bit_in; a bit is accepted on every rising edge where bit_valid=1.
- bit_in  input  1  serial data, normally the q output of the upstream register.
- sync_clr  input  1  synchronous clear of all state except the reset-only behaviour noted below.
- word_out  output  WIDTH  assembled word; stable while word_valid=1 and not consumed.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out on an edge where word_valid=1 and word_ready=1.
- bit_count  output  $clog2(WIDTH+1)  number of bits collected toward the next word, 0..WIDTH-1.
- overrun  output  1  sticky; a completed word was dropped.

## Operation
- Shift register `acc`:
  - on acceptance with MSB_FIRST=1: acc <= {acc[WIDTH-2:0], bit_in}.
  - with MSB_FIRST=0: acc <= {bit_in, acc[WIDTH-1:1]}.
- bit_count increments on each accepted bit. On the WIDTH-th bit it wraps to 0, and the word completes using the next value of acc, including the bit just accepted.
- Output FSM (out_state_t):
  - OUT_EMPTY -> OUT_FULL on completion.
  - OUT_FULL -> OUT_EMPTY on a handshake with no completion.
  - OUT_FULL stays OUT_FULL on handshake plus completion: the new word loads and word_valid remains 1.
  - OUT_FULL stays OUT_FULL on completion without handshake: the new word is dropped, word_out is unchanged, and overrun is set.
- overrun clears only on rst_n or sync_clr.
- sync_clr has priority over every other event on the same edge: bit_count=0, acc=0, state=OUT_EMPTY, overrun=0. The bit offered on that edge is discarded.
- A word_ready=1 pulse with word_valid=0 has no effect.
- bit_valid=0 holds acc and bit_count.
- An asserted rst_n mid-word discards the partial word. After release, collection restarts at bit 0.

## Timing
- Reset values: word_out=0, word_valid=0, bit_count=0, overrun=0, acc=0, state=OUT_EMPTY.
- Latency: word_valid rises and word_out updates on the same edge that captures the WIDTH-th bit. Both are visible for the whole following cycle.
- Back-to-back words at full rate (bit_valid held 1) need one handshake every WIDTH cycles to avoid overrun.
- A handshake and a completion on the same edge is not an overrun.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Package bit_deserializer_pkg:
  - typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t.
  - function cnt_w(width) returning $clog2(width+1).
- One natural sub-module, bit_shift_reg:
  - parameters WIDTH, MSB_FIRST; ports clk, rst_n, clr, shift_en, bit_in, value.
  - Instantiated once for acc.
- Top level holds the counter, output register and FSM.

## Test plan
- Reset and clear:
  - Pulse rst_n low for 1 ns mid-word after 3 accepted bits -> bit_count=0, word_valid=0 immediately.
  - Then feed 8 bits -> one word with no stale bits.
- MSB_FIRST=1, word_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive edges -> word_out=0xB2, and word_valid=1 on exactly the 8th edge.
- Repeat with MSB_FIRST=0 and the same bits -> word_out=0x4D.
- Gaps in enable:
  - Interleave bit_valid=0 for 4 cycles between every bit (alternate toggling bit_in, as the upstream stage does) -> bit_count holds during gaps.
  - Bits 0,1,0,1,0,1,0,1 give 0x55 (MSB_FIRST=1).
- Overrun:
  - With word_ready=0, stream 16 bits (0xA5 then 0x3C) -> word_out stays 0xA5 and overrun=1 after edge 16.
  - Then word_ready=1 -> word_valid drops, overrun stays 1 until sync_clr.
- Simultaneous events:
  - Handshake on the edge completing the next word -> word_valid stays 1, word_out changes to the new word, overrun=0.
  - sync_clr together with a completing bit -> word_valid=0, bit_count=0.
